wb_shadow_regfile: RTL and testbench

// - Consumer end of the writeback interface (RegWrite_W, rd_W, result_W).
// - Keeps an architectural shadow copy of the CPU register file from committed writebacks.
// - Serves decode-stage source reads (rs1, rs2) to the bench.
// - Counts commits; optionally buffers a commit log for a scoreboard drain.

---
 rtl/wb_shadow_regfile.sv | 99 +++++++++
 tb/tb_wb_shadow_regfile.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_shadow_regfile.sv
// rtl/wb_shadow_regfile.sv - writeback shadow register file, commit counter, optional commit log
// Optional commit-log FIFO built only when COMMIT_LOG_EN is defined.
module wb_shadow_regfile #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int LOG_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite_W,
    input  logic [4:0]      rd_W,
    input  logic [XLEN-1:0] result_W,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [31:0]     commit_cnt_o,
    output logic            log_valid_o,
    input  logic            log_ready_i,
    output logic [4:0]      log_rd_o,
    output logic [XLEN-1:0] log_data_o,
    output logic            log_overflow_o
);

    // Sized to the full 5-bit index space; entries at or above NREG are never written.
    logic [XLEN-1:0] shadow [32];
    logic            counted;

    assign counted = RegWrite_W && (rd_W != 5'd0) && ({1'b0, rd_W} < 6'(NREG));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
            commit_cnt_o <= '0;
        end else if (counted) begin
            shadow[rd_W] <= result_W;
            if (commit_cnt_o != 32'hFFFF_FFFF) commit_cnt_o <= commit_cnt_o + 32'd1;
        end
    end

    // Write-first bypass mirrors the CPU regfile so decode sees the same value.
    assign rd1_o = (rs1 == 5'd0) ? '0 :
                   (RegWrite_W && rd_W == rs1) ? result_W : shadow[rs1];
    assign rd2_o = (rs2 == 5'd0) ? '0 :
                   (RegWrite_W && rd_W == rs2) ? result_W : shadow[rs2];

`ifdef COMMIT_LOG_EN
    localparam int PW = $clog2(LOG_DEPTH);

    logic [4:0]      log_rd_mem   [LOG_DEPTH];
    logic [XLEN-1:0] log_data_mem [LOG_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            full;
    logic            pop;
    logic            push_ok;

    assign full    = (count == (PW+1)'(LOG_DEPTH));
    assign pop     = (count != '0) && log_ready_i;
    // A pop frees a slot in the same edge, so a full FIFO still accepts the push.
    assign push_ok = counted && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            log_rd_mem[wr_ptr]   <= rd_W;
            log_data_mem[wr_ptr] <= result_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            log_overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
            if (counted && !push_ok) log_overflow_o <= 1'b1;
        end
    end

    assign log_valid_o = (count != '0);
    assign log_rd_o    = log_valid_o ? log_rd_mem[rd_ptr]   : 5'd0;
    assign log_data_o  = log_valid_o ? log_data_mem[rd_ptr] : '0;
`else
    localparam int unused_log_depth = LOG_DEPTH;
    logic unused_log_ready;

    assign unused_log_ready = log_ready_i;
    assign log_valid_o      = 1'b0;
    assign log_rd_o         = 5'd0;
    assign log_data_o       = '0;
    assign log_overflow_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_shadow_regfile.sv
// tb/tb_wb_shadow_regfile.sv - self-checking bench for wb_shadow_regfile (both COMMIT_LOG_EN builds)
module tb_wb_shadow_regfile;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_W;
    logic [4:0]  rd_W;
    logic [31:0] result_W;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1_o;
    logic [31:0] rd2_o;
    logic [31:0] commit_cnt_o;
    logic        log_valid_o;
    logic        log_ready_i;
    logic [4:0]  log_rd_o;
    logic [31:0] log_data_o;
    logic        log_overflow_o;

    always #5 clk = ~clk;

    wb_shadow_regfile #(.XLEN(32), .NREG(32), .LOG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .RegWrite_W(RegWrite_W), .rd_W(rd_W), .result_W(result_W),
        .rs1(rs1), .rs2(rs2), .rd1_o(rd1_o), .rd2_o(rd2_o), .commit_cnt_o(commit_cnt_o),
        .log_valid_o(log_valid_o), .log_ready_i(log_ready_i), .log_rd_o(log_rd_o),
        .log_data_o(log_data_o), .log_overflow_o(log_overflow_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural registers, a commit count, and a bounded log queue.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [36:0] m_log [$];
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (RegWrite_W && rd_W == idx) return result_W;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        m_log.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic rdy);
        logic is_commit;
        is_commit = we && rd != 0;
`ifdef COMMIT_LOG_EN
        if (m_log.size() != 0 && rdy) void'(m_log.pop_front());
        if (is_commit) begin
            if (m_log.size() < DEPTH) m_log.push_back({rd, data});
            else m_ovf = 1'b1;
        end
`endif
        if (is_commit) begin
            m_regs[rd] = data;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] data,
                         input logic [4:0] a, input logic [4:0] b, input logic rdy);
        @(negedge clk);
        rst = 1'b0; RegWrite_W = we; rd_W = rd; result_W = data;
        rs1 = a; rs2 = b; log_ready_i = rdy;
        #1;
        chk("rd1", rd1_o, m_read(a));
        chk("rd2", rd2_o, m_read(b));
        chk("commit_cnt", commit_cnt_o, m_cnt);
        chk("log_valid", {31'd0, log_valid_o}, {31'd0, m_log.size() != 0});
        chk("log_rd", {27'd0, log_rd_o}, (m_log.size() != 0) ? {27'd0, m_log[0][36:32]} : 32'd0);
        chk("log_data", log_data_o, (m_log.size() != 0) ? m_log[0][31:0] : 32'd0);
        chk("log_overflow", {31'd0, log_overflow_o}, {31'd0, m_ovf});
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step(RegWrite_W, rd_W, result_W, log_ready_i);
    endtask

    task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] data,
                         input logic [4:0] a, input logic [4:0] b, input logic rdy);
        drive(we, rd, data, a, b, rdy);
        edge_step();
    endtask

    task automatic do_reset(input logic we, input logic [4:0] rd, input logic [31:0] data,
                            input logic rdy);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; RegWrite_W = we; rd_W = rd; result_W = data;
            rs1 = 5'd0; rs2 = 5'd0; log_ready_i = rdy;
            @(posedge clk);
        end
        model_reset();
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ecnt;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          n;
        logic [4:0]  last_rd;
        logic [4:0]  r;

        tbl[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,    32'd0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,    32'd0};
        tbl[2] = '{1'b1, 5'd7,  32'h1234,     5'd7,  5'd0,  32'h1234,     32'h0,    32'd0};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h1234,     32'h1234, 32'd1};
        tbl[4] = '{1'b1, 5'd7,  32'h5555,     5'd7,  5'd3,  32'h5555,     32'h0,    32'd1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd3,  32'h5555,     32'h0,    32'd2};
        tbl[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd7,  32'hFFFFFFFF, 32'h5555, 32'd2};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,    32'd3};

        // T1 reset
        do_reset(1'b0, 5'd0, 32'd0, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b0);
        chk("t1_rd1", rd1_o, 32'd0);
        chk("t1_rd2", rd2_o, 32'd0);
        chk("t1_cnt", commit_cnt_o, 32'd0);
        chk("t1_valid", {31'd0, log_valid_o}, 32'd0);
        chk("t1_ovf", {31'd0, log_overflow_o}, 32'd0);
        edge_step();

        // T2/T3 x0 guard and bypass vectors
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].we, tbl[i].rd, tbl[i].data, tbl[i].a, tbl[i].b, 1'b0);
            chk($sformatf("vec%0d_rd1", i), rd1_o, tbl[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2_o, tbl[i].e2);
            chk($sformatf("vec%0d_cnt", i), commit_cnt_o, tbl[i].ecnt);
            edge_step();
        end

        // T4 counter and in-order drain
        do_reset(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 1; i <= 10; i++) cycle(1'b1, 5'(i), 32'(i * 3), 5'd0, 5'd0, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd1, 1'b0);
        chk("t4_cnt", commit_cnt_o, 32'd10);
        chk("t4_x10", rd1_o, 32'd30);
        chk("t4_x1", rd2_o, 32'd3);
        edge_step();
`ifdef COMMIT_LOG_EN
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
            chk("t4_drain_valid", {31'd0, log_valid_o}, 32'd1);
            chk("t4_drain_rd", {27'd0, log_rd_o}, 32'(i));
            chk("t4_drain_data", log_data_o, 32'(i * 3));
            edge_step();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        chk("t4_empty", {31'd0, log_valid_o}, 32'd0);
        edge_step();

        // T5 overflow, then push+pop while full
        do_reset(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 1; i <= 17; i++) cycle(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0);
        drive(1'b1, 5'd20, 32'd20, 5'd0, 5'd0, 1'b1);
        chk("t5_ovf", {31'd0, log_overflow_o}, 32'd1);
        chk("t5_cnt", commit_cnt_o, 32'd17);
        chk("t5_head", {27'd0, log_rd_o}, 32'd1);
        edge_step();
        n = 0;
        last_rd = 5'd0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
            if (log_valid_o) begin
                n++;
                last_rd = log_rd_o;
            end
            edge_step();
        end
        chk("t5_entries_after_pushpop", 32'(n), 32'd16);
        chk("t5_last_rd", {27'd0, last_rd}, 32'd20);
        chk("t5_cnt_final", commit_cnt_o, 32'd18);
`endif

        // T6 reset mid-stream
        for (int i = 1; i <= 5; i++) cycle(1'b1, 5'(i), 32'hA0 + 32'(i), 5'd0, 5'd0, 1'b0);
        do_reset(1'b1, 5'd3, 32'hCAFE, 1'b1);
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 1'b0);
        chk("t6_x3", rd1_o, 32'd0);
        chk("t6_x5", rd2_o, 32'd0);
        chk("t6_cnt", commit_cnt_o, 32'd0);
        chk("t6_valid", {31'd0, log_valid_o}, 32'd0);
        edge_step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 3) != 0), r, $urandom(),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
